// File: rtl/pipe_trace_capture.sv
// Pipeline trace capture: circular buffer of per-cycle stage snapshots with a
// channel-0 compare trigger, post-trigger window and indexed readback.
//
// state  | meaning
// IDLE   | no capture, waiting for arm
// ARMED  | writing every cycle, watching for the trigger
// POST   | writing the post-trigger window, down-counter running
// DONE   | contents frozen until the next arm
module pipe_trace_capture #(
  parameter int NUM_STAGES = 5,
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 16,
  parameter int POST_TRIG  = 4,
  parameter int CYC_W      = 32,
  localparam int AW        = $clog2(DEPTH),
  localparam int ENTRY_W   = NUM_STAGES*DATA_W + NUM_STAGES + CYC_W
) (
  input  logic                         CLK,
  input  logic                         RESET_N,
  input  logic [NUM_STAGES*DATA_W-1:0] stage_data,
  input  logic [NUM_STAGES-1:0]        stage_valid,
  input  logic                         arm,
  input  logic [DATA_W-1:0]            trig_value,
  input  logic                         rd_en,
  input  logic [AW-1:0]                rd_idx,
  output logic [ENTRY_W-1:0]           rd_data,
  output logic                         rd_vld,
  output logic [CYC_W-1:0]             cycle_count,
  output logic [1:0]                   state,
  output logic [AW:0]                  entries,
  output logic                         done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ARMED = 2'b01,
    S_POST  = 2'b10,
    S_DONE  = 2'b11
  } state_e;

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] POST_C  = (AW+1)'(POST_TRIG);

  state_e               state_q, state_d;
  logic [CYC_W-1:0]     cyc_q, cyc_d;
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW:0]          entries_q, entries_d;
  logic [AW:0]          post_cnt_q, post_cnt_d;
  logic                 rd_vld_q, rd_vld_d;
  logic [ENTRY_W-1:0]   rd_data_q, rd_data_d;

  logic [ENTRY_W-1:0]   mem [DEPTH];
  logic                 wr_en;
  logic                 trig_hit;
  logic [ENTRY_W-1:0]   wr_entry;
  logic [AW-1:0]        oldest_ptr;
  logic [AW-1:0]        rd_addr;

  assign trig_hit = stage_valid[0] && (stage_data[DATA_W-1:0] == trig_value);
  assign wr_entry = {cyc_q, stage_valid, stage_data};

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    entries_d  = entries_q;
    post_cnt_d = post_cnt_q;
    cyc_d      = cyc_q + CYC_W'(1);
    wr_en      = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (arm) begin
          state_d   = S_ARMED;
          wr_ptr_d  = '0;
          entries_d = '0;
        end
      end
      S_ARMED: begin
        wr_en = 1'b1;
        if (trig_hit) begin
          state_d    = (POST_TRIG == 0) ? S_DONE : S_POST;
          post_cnt_d = POST_C;
        end
      end
      S_POST: begin
        wr_en      = 1'b1;
        post_cnt_d = post_cnt_q - (AW+1)'(1);
        if (post_cnt_q == (AW+1)'(1)) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    if (wr_en) begin
      wr_ptr_d  = wr_ptr_q + AW'(1);
      entries_d = (entries_q == DEPTH_C) ? entries_q : entries_q + (AW+1)'(1);
    end
  end

  // Once the buffer has wrapped, the slot about to be overwritten is the oldest.
  assign oldest_ptr = (entries_q == DEPTH_C) ? wr_ptr_q : '0;
  assign rd_addr    = oldest_ptr + rd_idx;

  always_comb begin
    rd_vld_d  = rd_en;
    rd_data_d = rd_data_q;
    if (rd_en) begin
      if ({1'b0, rd_idx} < entries_q) rd_data_d = mem[rd_addr];
      else                            rd_data_d = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q    <= S_IDLE;
      cyc_q      <= '0;
      wr_ptr_q   <= '0;
      entries_q  <= '0;
      post_cnt_q <= '0;
      rd_vld_q   <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      wr_ptr_q   <= wr_ptr_d;
      entries_q  <= entries_d;
      post_cnt_q <= post_cnt_d;
      rd_vld_q   <= rd_vld_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // Memory is not reset; a same-address read sees the pre-write contents.
  always_ff @(posedge CLK) begin
    if (RESET_N && wr_en) mem[wr_ptr_q] <= wr_entry;
  end

  assign rd_data     = rd_data_q;
  assign rd_vld      = rd_vld_q;
  assign cycle_count = cyc_q;
  assign state       = state_q;
  assign entries     = entries_q;
  assign done        = (state_q == S_DONE);

endmodule
